melody_scheduler: RTL and testbench
===================================

Name: melody_scheduler

Overview:
- Sequences the tone generator: steps through a song stored in an external synchronous ROM and drives note_div and volumn to the buzzer_control block.
- A one-shot sound-effect (SFX) request pre-empts the song, holding its position and remaining beats, then resumes it.
- Sits between the game/UI control logic and the buzzer tone generator.

Parameters:
- BEAT_DIV, 2500000, clk cycles per beat (62.5 ms at 40 MHz); minimum value 2.
- ADDR_W, 6, ROM address width (64 entries).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- play  in  1  pulse: start song from address 0 (restarts if already playing)
- stop  in  1  pulse: abort song and SFX, go silent
- loop_en  in  1  level: on end marker, restart from address 0
- vol_level  in  3  volume step, 0 = mute, 7 = loudest
- sfx_req  in  1  level: SFX request
- sfx_div  in  20  SFX note divider, sampled on acceptance
- sfx_beats  in  4  SFX length in beats, sampled on acceptance; 0 is treated as 1
- sfx_ack  out  1  one-cycle pulse when the SFX is accepted
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  24  entry: [23:20] beats (0 = end marker), [19:0] note_div (0 = rest)
- note_div  out  20  to the tone generator
- volumn  out  16  to the tone generator amplitude input
- busy  out  1  high in any state except IDLE
- song_done  out  1  one-cycle pulse when a non-looping song ends

Behaviour:
- Reset values:
  - state = IDLE, rom_addr = 0, note_div = 0, volumn = 16'h8000.
  - sfx_ack = 0, busy = 0, song_done = 0, beat counters = 0.
- Volume mapping: volumn = 16'h8000 + vol_level * 16'h0FFF, 16-bit, no overflow (max 16'hEFF9).
  - Forced to 16'h8000 in IDLE, during a rest (note_div = 0), and in FETCH/LOAD before the first note of a song.
  - vol_level changes take effect on the next cycle.
- States:
  - IDLE
    - play -> FETCH with rom_addr = 0.
    - sfx_req -> SFX.
  - FETCH: one cycle; address presented. ROM latency is 1 cycle, so data is valid in LOAD.
  - LOAD: sample rom_data.
    - beats != 0: latch the note and beats, clear the beat prescaler, drive note_div, go to PLAY.
    - beats == 0 and loop_en = 1: rom_addr = 0, go to FETCH.
    - beats == 0 and loop_en = 0: pulse song_done, go to IDLE.
  - PLAY: a note lasts exactly beats * BEAT_DIV cycles.
    - Beat tick is asserted when the prescaler reaches BEAT_DIV-1; the remaining-beat count decrements on each tick.
    - On the last tick: rom_addr + 1 (wraps mod 2^ADDR_W), go to FETCH.
    - The previous note_div/volumn hold through FETCH/LOAD, a 2-cycle gap.
  - SFX:
    - note_div = sfx_div; the prescaler is cleared on entry.
    - Lasts max(sfx_beats, 1) * BEAT_DIV cycles, then returns to the saved state (IDLE or PLAY).
    - Resumes with the saved rom_addr, the saved remaining beats and the saved note_div. The partially elapsed beat is discarded and the prescaler cleared.
- SFX acceptance:
  - sfx_req is sampled only in IDLE or PLAY; sfx_ack pulses in the cycle the state enters SFX.
  - A request in FETCH/LOAD waits until the state is PLAY.
  - sfx_req held high after SFX completes re-triggers a new SFX; the request is level-sensitive.
- play is ignored in SFX.
- Priority on simultaneous events: stop > play > sfx_req.
  - stop in any state -> IDLE next cycle, silent outputs, no song_done, no sfx_ack.
- rst mid-note: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package melody_pkg:
  - State encoding localparams: IDLE, FETCH, LOAD, PLAY, SFX.
  - ROM field positions: DUR_MSB=23, DUR_LSB=20, DIV_MSB=19.
  - SILENCE = 16'h8000, VOL_STEP = 16'h0FFF.
- Sub-module beat_timer (params BEAT_DIV):
  - Ports: clk, rst, clr, tick.
  - Prescaler counter; tick is a one-cycle pulse every BEAT_DIV cycles after clr.

Test Plan (BEAT_DIV = 4):
- ROM {3 beats, div 100}, {1 beat, div 0}, {0 end}; vol_level 7; pulse play, loop_en 0 -> note_div = 100 and volumn = 16'hEFF9 for 12 cycles; then rest with volumn = 16'h8000 for 4 cycles; song_done pulses once; busy falls.
- Same ROM, loop_en 1 -> after the end marker, rom_addr returns to 0 and div 100 replays; song_done never pulses.
- SFX pre-emption: sfx_req with sfx_div 50, sfx_beats 2 asserted after 1 beat of the 3-beat note -> sfx_ack pulses once; note_div = 50 for 8 cycles; then note_div 100 for 8 more cycles (2 remaining beats).
- sfx_beats 0 in IDLE -> note_div = 50 for exactly 4 cycles, then IDLE with note_div 0.
- play and stop in the same cycle during PLAY -> IDLE, volumn 16'h8000, no song_done; stop with sfx_req -> no sfx_ack.
- rst asserted mid-note -> note_div 0, volumn 16'h8000, busy 0 without waiting for a clock edge; play afterwards restarts at rom_addr 0.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody scheduler: FSM states, ROM entry
// field positions and the volume mapping.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        SFX   = 3'd4
    } state_t;

    localparam int DUR_MSB = 23;
    localparam int DUR_LSB = 20;
    localparam int DIV_MSB = 19;

    localparam logic [15:0] SILENCE  = 16'h8000;
    localparam logic [15:0] VOL_STEP = 16'h0FFF;

    // 7 * 0x0FFF + 0x8000 = 0xEFF9, so the 16-bit sum never overflows.
    function automatic logic [15:0] vol_map(input logic [2:0] level);
        return SILENCE + 16'(level) * VOL_STEP;
    endfunction

endpackage

// File: rtl/melody_scheduler_beat_timer.sv
// Beat prescaler: tick pulses for one cycle every BEAT_DIV cycles after clr.
module beat_timer #(
    parameter int BEAT_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/melody_scheduler.sv
// Song sequencer for the buzzer tone generator: walks a synchronous song ROM and
// lets a one-shot sound effect pre-empt the song, then resume it where it left off.
module melody_scheduler
    import melody_pkg::*;
#(
    parameter int BEAT_DIV = 2500000,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [2:0]        vol_level,
    input  logic              sfx_req,
    input  logic [19:0]       sfx_div,
    input  logic [3:0]        sfx_beats,
    output logic              sfx_ack,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [19:0]       note_div,
    output logic [15:0]       volumn,
    output logic              busy,
    output logic              song_done
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] rom_addr_n;
    logic [19:0]       note_div_n, saved_div, saved_div_n;
    logic [15:0]       volumn_n;
    logic [3:0]        beats_left, beats_left_n;
    logic [3:0]        sfx_left, sfx_left_n;
    logic              resume_play, resume_play_n;
    logic              sfx_ack_n, song_done_n;
    logic              tick, clr;
    logic [3:0]        dur;
    logic [19:0]       div;

    assign dur  = rom_data[DUR_MSB:DUR_LSB];
    assign div  = rom_data[DIV_MSB:0];
    assign busy = (state != IDLE);

    beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_n       = state;
        rom_addr_n    = rom_addr;
        note_div_n    = note_div;
        beats_left_n  = beats_left;
        sfx_left_n    = sfx_left;
        saved_div_n   = saved_div;
        resume_play_n = resume_play;
        sfx_ack_n     = 1'b0;
        song_done_n   = 1'b0;

        if (stop) begin
            state_n    = IDLE;
            note_div_n = '0;
        end else if (play && state != SFX) begin
            state_n    = FETCH;
            rom_addr_n = '0;
            note_div_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sfx_req) begin
                        state_n       = SFX;
                        resume_play_n = 1'b0;
                        note_div_n    = sfx_div;
                        sfx_left_n    = (sfx_beats == 4'd0) ? 4'd1 : sfx_beats;
                        sfx_ack_n     = 1'b1;
                    end
                end
                FETCH: state_n = LOAD;
                LOAD: begin
                    if (dur != 4'd0) begin
                        state_n      = PLAY;
                        note_div_n   = div;
                        beats_left_n = dur;
                    end else if (loop_en) begin
                        state_n    = FETCH;
                        rom_addr_n = '0;
                    end else begin
                        state_n     = IDLE;
                        note_div_n  = '0;
                        song_done_n = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick && beats_left == 4'd1) begin
                        state_n    = FETCH;
                        rom_addr_n = rom_addr + ADDR_W'(1);
                    end else begin
                        // A beat completing in the same cycle as pre-emption still counts.
                        if (tick)
                            beats_left_n = beats_left - 4'd1;
                        if (sfx_req) begin
                            state_n       = SFX;
                            resume_play_n = 1'b1;
                            saved_div_n   = note_div;
                            note_div_n    = sfx_div;
                            sfx_left_n    = (sfx_beats == 4'd0) ? 4'd1 : sfx_beats;
                            sfx_ack_n     = 1'b1;
                        end
                    end
                end
                SFX: begin
                    if (tick) begin
                        if (sfx_left == 4'd1) begin
                            state_n    = resume_play ? PLAY : IDLE;
                            note_div_n = resume_play ? saved_div : 20'd0;
                        end else begin
                            sfx_left_n = sfx_left - 4'd1;
                        end
                    end
                end
                default: begin
                    state_n    = IDLE;
                    note_div_n = '0;
                end
            endcase
        end

        volumn_n = (state_n == IDLE || note_div_n == 20'd0) ? SILENCE : vol_map(vol_level);

        // Prescaler restarts on every state change, and idles at zero outside PLAY/SFX.
        clr = (state_n != state) || !(state inside {PLAY, SFX});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rom_addr    <= '0;
            note_div    <= '0;
            volumn      <= SILENCE;
            beats_left  <= '0;
            sfx_left    <= '0;
            saved_div   <= '0;
            resume_play <= 1'b0;
            sfx_ack     <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            state       <= state_n;
            rom_addr    <= rom_addr_n;
            note_div    <= note_div_n;
            volumn      <= volumn_n;
            beats_left  <= beats_left_n;
            sfx_left    <= sfx_left_n;
            saved_div   <= saved_div_n;
            resume_play <= resume_play_n;
            sfx_ack     <= sfx_ack_n;
            song_done   <= song_done_n;
        end
    end

endmodule

// File: tb/tb_melody_scheduler.sv
// Directed bench for melody_scheduler with BEAT_DIV = 4 and a small synchronous
// song ROM model; expected values are hand-derived cycle by cycle.
module tb_melody_scheduler;

    localparam int BEAT_DIV = 4;
    localparam int ADDR_W   = 6;

    logic              clk;
    logic              rst;
    logic              play;
    logic              stop;
    logic              loop_en;
    logic [2:0]        vol_level;
    logic              sfx_req;
    logic [19:0]       sfx_div;
    logic [3:0]        sfx_beats;
    logic              sfx_ack;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic [19:0]       note_div;
    logic [15:0]       volumn;
    logic              busy;
    logic              song_done;

    logic [23:0] rom [64];

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int ack_cnt   = 0;
    int done_base;
    int ack_base;

    melody_scheduler #(.BEAT_DIV(BEAT_DIV), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .stop      (stop),
        .loop_en   (loop_en),
        .vol_level (vol_level),
        .sfx_req   (sfx_req),
        .sfx_div   (sfx_div),
        .sfx_beats (sfx_beats),
        .sfx_ack   (sfx_ack),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_div  (note_div),
        .volumn    (volumn),
        .busy      (busy),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (song_done === 1'b1) done_cnt++;
        if (sfx_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 24'h0;
        rom[0] = {4'd3, 20'd100};
        rom[1] = {4'd1, 20'd0};
        rom[2] = 24'h0;

        rst = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0;
        vol_level = 3'd7; sfx_req = 1'b0; sfx_div = 20'd0; sfx_beats = 4'd0;
        run(2);
        #2 rst = 1'b0;
        step();

        check("reset_state_busy", 32'(busy), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_note_div", 32'(note_div), 32'd0);
        check("reset_volumn", 32'(volumn), 32'h8000);
        check("reset_sfx_ack", 32'(sfx_ack), 32'd0);
        check("reset_song_done", 32'(song_done), 32'd0);

        // Plain song, no loop
        done_base = done_cnt;
        play = 1'b1;
        step();
        play = 1'b0;
        check("song_fetch_busy", 32'(busy), 32'd1);
        check("song_fetch_vol", 32'(volumn), 32'h8000);
        step();
        check("song_load_div", 32'(note_div), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("song_note_div", 32'(note_div), 32'd100);
            check("song_note_vol", 32'(volumn), 32'hEFF9);
        end
        step();
        check("song_gap_addr", 32'(rom_addr), 32'd1);
        check("song_gap_div", 32'(note_div), 32'd100);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("song_rest_div", 32'(note_div), 32'd0);
            check("song_rest_vol", 32'(volumn), 32'h8000);
        end
        step();
        check("song_end_addr", 32'(rom_addr), 32'd2);
        step();
        step();
        check("song_done_pulse", 32'(song_done), 32'd1);
        check("song_end_busy", 32'(busy), 32'd0);
        check("song_end_div", 32'(note_div), 32'd0);
        step();
        check("song_done_clear", 32'(song_done), 32'd0);
        check("song_done_once", 32'(done_cnt - done_base), 32'd1);

        // Looping song
        done_base = done_cnt;
        loop_en = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        run(21);
        check("loop_marker_addr", 32'(rom_addr), 32'd2);
        step();
        check("loop_restart_addr", 32'(rom_addr), 32'd0);
        check("loop_restart_busy", 32'(busy), 32'd1);
        run(2);
        check("loop_replay_div", 32'(note_div), 32'd100);
        check("loop_replay_vol", 32'(volumn), 32'hEFF9);
        check("loop_no_done", 32'(done_cnt - done_base), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'd0);
        check("loop_stop_div", 32'(note_div), 32'd0);
        loop_en = 1'b0;

        // SFX pre-empts the 3-beat note after its first beat
        ack_base = ack_cnt;
        play = 1'b1;
        step();
        play = 1'b0;
        run(6);
        sfx_req = 1'b1; sfx_div = 20'd50; sfx_beats = 4'd2;
        step();
        sfx_req = 1'b0;
        check("pre_ack", 32'(sfx_ack), 32'd1);
        check("pre_sfx_div", 32'(note_div), 32'd50);
        check("pre_sfx_vol", 32'(volumn), 32'hEFF9);
        for (int i = 0; i < 7; i++) begin
            step();
            check("pre_sfx_hold", 32'(note_div), 32'd50);
        end
        check("pre_ack_clear", 32'(sfx_ack), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("pre_resume_div", 32'(note_div), 32'd100);
            check("pre_resume_addr", 32'(rom_addr), 32'd0);
        end
        step();
        check("pre_next_addr", 32'(rom_addr), 32'd1);
        check("pre_ack_once", 32'(ack_cnt - ack_base), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // SFX from IDLE with zero beats, plus a volume change mid-effect
        sfx_req = 1'b1; sfx_div = 20'd50; sfx_beats = 4'd0;
        step();
        sfx_req = 1'b0;
        check("idle_sfx_ack", 32'(sfx_ack), 32'd1);
        check("idle_sfx_div", 32'(note_div), 32'd50);
        check("idle_sfx_busy", 32'(busy), 32'd1);
        vol_level = 3'd3;
        step();
        check("idle_sfx_vol3", 32'(volumn), 32'hAFFD);
        vol_level = 3'd7;
        run(2);
        check("idle_sfx_last", 32'(note_div), 32'd50);
        check("idle_sfx_vol7", 32'(volumn), 32'hEFF9);
        step();
        check("idle_sfx_end_div", 32'(note_div), 32'd0);
        check("idle_sfx_end_busy", 32'(busy), 32'd0);
        check("idle_sfx_end_vol", 32'(volumn), 32'h8000);

        // Priority: stop over play, stop over sfx_req, play over sfx_req
        done_base = done_cnt;
        play = 1'b1;
        step();
        play = 1'b0;
        run(4);
        check("prio_playing_div", 32'(note_div), 32'd100);
        play = 1'b1; stop = 1'b1;
        step();
        play = 1'b0; stop = 1'b0;
        check("prio_stop_busy", 32'(busy), 32'd0);
        check("prio_stop_vol", 32'(volumn), 32'h8000);
        check("prio_stop_done", 32'(song_done), 32'd0);
        stop = 1'b1; sfx_req = 1'b1;
        step();
        stop = 1'b0; sfx_req = 1'b0;
        check("prio_stop_sfx_ack", 32'(sfx_ack), 32'd0);
        check("prio_stop_sfx_busy", 32'(busy), 32'd0);
        play = 1'b1; sfx_req = 1'b1;
        step();
        play = 1'b0; sfx_req = 1'b0;
        check("prio_play_sfx_ack", 32'(sfx_ack), 32'd0);
        check("prio_play_sfx_div", 32'(note_div), 32'd0);
        check("prio_play_sfx_busy", 32'(busy), 32'd1);
        check("prio_no_done", 32'(done_cnt - done_base), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Asynchronous reset mid-note, then restart
        play = 1'b1;
        step();
        play = 1'b0;
        run(4);
        check("rst_pre_div", 32'(note_div), 32'd100);
        #2 rst = 1'b1;
        #1;
        check("rst_async_div", 32'(note_div), 32'd0);
        check("rst_async_vol", 32'(volumn), 32'h8000);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_addr", 32'(rom_addr), 32'd0);
        #2 rst = 1'b0;
        play = 1'b1;
        step();
        play = 1'b0;
        check("rst_restart_addr", 32'(rom_addr), 32'd0);
        check("rst_restart_busy", 32'(busy), 32'd1);
        run(2);
        check("rst_restart_div", 32'(note_div), 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
